// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants, counter widths and FSM state type for the
// VGA timing generator (800x600 @ 60 Hz on a 40 MHz pixel clock).
package vga_pkg;

   localparam int H_ACTIVE_DEF = 800;
   localparam int H_FP_DEF     = 40;
   localparam int H_SYNC_DEF   = 128;
   localparam int H_BP_DEF     = 88;

   localparam int V_ACTIVE_DEF = 600;
   localparam int V_FP_DEF     = 1;
   localparam int V_SYNC_DEF   = 4;
   localparam int V_BP_DEF     = 23;

   localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   localparam int X_W = 11;
   localparam int Y_W = 10;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: sync strobes, display enable, pixel position and
// line/frame start pulses, driven by the timing generator.
interface vga_timing_gen_if;
   import vga_pkg::*;

   logic           hsync;
   logic           vsync;
   logic           de;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic           frame_start;
   logic           line_start;

   modport master (
      output hsync, vsync, de, x, y, frame_start, line_start
   );

   modport slave (
      input hsync, vsync, de, x, y, frame_start, line_start
   );

endinterface

// File: rtl/vga_timing_gen_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the async level through two flops to settle metastability.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: runs the raster counters while the pixel PLL is
// locked and produces registered sync, display-enable and position outputs.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pll_locked,
   vga_timing_gen_if.master   vid
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [X_W-1:0] H_LAST      = X_W'(H_TOT - 1);
   localparam logic [X_W-1:0] H_ACT_END   = X_W'(H_ACTIVE);
   localparam logic [X_W-1:0] H_SYNC_BEG  = X_W'(H_ACTIVE + H_FP);
   localparam logic [X_W-1:0] H_SYNC_END  = X_W'(H_ACTIVE + H_FP + H_SYNC);

   localparam logic [Y_W-1:0] V_LAST      = Y_W'(V_TOT - 1);
   localparam logic [Y_W-1:0] V_ACT_END   = Y_W'(V_ACTIVE);
   localparam logic [Y_W-1:0] V_SYNC_BEG  = Y_W'(V_ACTIVE + V_FP);
   localparam logic [Y_W-1:0] V_SYNC_END  = Y_W'(V_ACTIVE + V_FP + V_SYNC);

   logic           locked_s;
   state_t         state;
   logic [X_W-1:0] h_cnt;
   logic [Y_W-1:0] v_cnt;
   logic           run;

   sync_2ff u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_locked),
      .q   (locked_s)
   );

   // Lock-driven FSM and raster counters; counters are forced to the
   // origin whenever the FSM is (or is about to be) idle, so a re-lock
   // always starts a fresh frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               h_cnt <= '0;
               v_cnt <= '0;
               if (locked_s) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (!locked_s) begin
                  state <= IDLE;
                  h_cnt <= '0;
                  v_cnt <= '0;
               end else if (h_cnt == H_LAST) begin
                  h_cnt <= '0;
                  v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
               end else begin
                  h_cnt <= h_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               h_cnt <= '0;
               v_cnt <= '0;
            end
         endcase
      end
   end

   assign run = (state == RUN);

   // Output register stage: decode the current counter values one clock
   // late so every output is glitch-free; strobes are gated by RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vid.de          <= 1'b0;
         vid.hsync       <= 1'b0;
         vid.vsync       <= 1'b0;
         vid.x           <= '0;
         vid.y           <= '0;
         vid.frame_start <= 1'b0;
         vid.line_start  <= 1'b0;
      end else begin
         vid.de          <= run && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
         vid.hsync       <= run && (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
         vid.vsync       <= run && (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
         vid.x           <= h_cnt;
         vid.y           <= v_cnt;
         vid.frame_start <= run && (h_cnt == '0) && (v_cnt == '0);
         vid.line_start  <= run && (h_cnt == '0);
      end
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 40, horizontal front porch in clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 128, hsync width in clocks.
REQ-004 The block SHALL have parameter H_BP, default 88, horizontal back porch in clocks.
REQ-005 The block SHALL have parameter V_ACTIVE, default 600, visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 1, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 4, vsync width in lines.
REQ-008 The block SHALL have parameter V_BP, default 23, vertical back porch in lines.
REQ-009 The block SHALL have port clk, input, 1 bit: pixel clock, 40 MHz PLL output.
REQ-010 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-011 The block SHALL have port pll_locked, input, 1 bit: PLL lock flag, asynchronous to clk.
REQ-012 The block SHALL have port hsync, output, 1 bit: horizontal sync, active-high.
REQ-013 The block SHALL have port vsync, output, 1 bit: vertical sync, active-high.
REQ-014 The block SHALL have port de, output, 1 bit: display enable, high in the visible area.
REQ-015 The block SHALL have port x, output, 11 bits: current horizontal count.
REQ-016 The block SHALL have port y, output, 10 bits: current vertical count.
REQ-017 The block SHALL have port frame_start, output, 1 bit: one-clock pulse with pixel (0,0).
REQ-018 The block SHALL have port line_start, output, 1 bit: one-clock pulse with x=0 of every line.

Function
REQ-019 pll_locked SHALL pass through a 2-flop synchronizer before any use; locked_s is the synchronizer output.
REQ-020 The FSM SHALL have two states: IDLE and RUN. IDLE goes to RUN when locked_s=1. RUN goes to IDLE when locked_s=0.
REQ-021 In IDLE, h_cnt and v_cnt SHALL be held at 0.
REQ-022 In RUN, h_cnt SHALL count 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (1056), then wrap to 0.
REQ-023 v_cnt SHALL increment only on the h_cnt wrap, counting 0..V_TOTAL-1, where V_TOTAL = sum of the V parameters (628), then wrap to 0.
REQ-024 All outputs SHALL be registered, with a latency of 1 clk from the counter values.
REQ-025 de SHALL be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-026 hsync SHALL be 1 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (840..967).
REQ-027 vsync SHALL be 1 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (601..604).
REQ-028 x and y SHALL equal h_cnt and v_cnt; they SHALL remain valid outside the active area.
REQ-029 frame_start SHALL be 1 iff h_cnt=0 and v_cnt=0 in RUN. line_start SHALL be 1 iff h_cnt=0 in RUN.
REQ-030 In IDLE, de, hsync, vsync, frame_start and line_start SHALL all be 0.
REQ-031 On loss of lock mid-frame, all outputs SHALL go inactive 1 clk after the FSM returns to IDLE.
REQ-032 On re-lock after loss of lock, the frame SHALL restart at (0,0) with no partial-frame resume.

Reset
REQ-033 rst SHALL asynchronously clear synchronizer flops, FSM (to IDLE), counters and all outputs to 0.
REQ-034 After rst deasserts with pll_locked=1, de SHALL first be 1 at the 4th rising clk edge: 2 synchronizer edges, 1 FSM edge, 1 output-register edge.

Structure
REQ-035 Package vga_pkg SHALL hold the default timing constants, the derived H_TOTAL and V_TOTAL, the counter widths, and the FSM state enum.
REQ-036 The lock synchronizer SHALL be a sub-module named sync_2ff (1 bit, async active-high reset, clk/rst ports).

Verification
REQ-037 Reset, then pll_locked=1 -> de=1, x=0, y=0 and frame_start=1 at edge 4; frame_start is 0 at all other edges of the frame.
REQ-038 Free run for one line -> de high for 800 clks, hsync high for 128 clks starting at x=840, line_start period 1056 clks.
REQ-039 Free run for one frame -> vsync high for 4×1056 clks at y=601..604, frame_start period 663168 clks, y wraps from 627 to 0.
REQ-040 Drop pll_locked at x=300, y=200 -> all outputs 0 within 4 clks; re-assert -> next frame_start is at (0,0).
REQ-041 Assert rst at x=500, y=100 -> all outputs 0 immediately (asynchronous); deassert -> restart per REQ-034.
